// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller slice: lamp codes,
// debounce FSM states and timing constants at a 50 MHz system clock.
package tlc_pkg;

    // Farm / highway lamp encodings as driven by the controller
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    // Debounce FSM states; the encoding is visible on the debState test port
    typedef enum logic [1:0] {
        ABSENT   = 2'b00,
        RISE_CHK = 2'b01,
        PRESENT  = 2'b10,
        FALL_CHK = 2'b11
    } deb_state_t;

    // Timing constants in clock cycles
    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned ONE_SEC        = CLK_HZ;
    localparam int unsigned THREE_SEC      = 3 * CLK_HZ;
    localparam int unsigned FIFTEEN_SEC    = 15 * CLK_HZ;
    localparam int unsigned THIRTY_SEC     = 30 * CLK_HZ;
    localparam int unsigned DEBOUNCE_100MS = CLK_HZ / 10;

    // Only the exact green code counts as green; illegal 00 is not green
    function automatic logic is_green(input logic [1:0] lamp);
        return (lamp == LAMP_GREEN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous
// active-low reset clears both stages.
module sync_2ff (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Metastability filter: d -> s1 -> q
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/farm_sensor_cond.sv
// Farm-road vehicle detector conditioning: synchroniser, symmetric debounce
// filter, latched service request and saturating arrival tally.
module farm_sensor_cond
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100MS,
    parameter int unsigned CNT_W           = 23,
    parameter int unsigned TALLY_W         = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               sensorRaw,
    input  logic [1:0]         farmSignal,
    input  logic               tallyClr,
    output logic               farmSensor,
    output logic               vehiclePresent,
    output logic               requestPending,
    output logic [TALLY_W-1:0] vehicleTally,
    output logic [1:0]         debState
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

    logic             s2;
    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             arrival;
    logic             arr_q;
    logic             green;

    assign green = is_green(farmSignal);

    sync_2ff u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (sensorRaw),
        .q   (s2)
    );

    // Debounce state and stability counter registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= ABSENT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Debounce next-state: a level change is accepted once it has been seen
    // on DEBOUNCE_CYCLES+1 consecutive samples
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        arrival = 1'b0;
        case (state)
            ABSENT: begin
                if (s2) begin
                    state_n = RISE_CHK;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    state_n = ABSENT;
                    cnt_n   = '0;
                end else if (cnt == DEB_LIM) begin
                    state_n = PRESENT;
                    cnt_n   = '0;
                    arrival = 1'b1;
                end else begin
                    cnt_n   = cnt + 1'b1;
                end
            end
            PRESENT: begin
                if (!s2) begin
                    state_n = FALL_CHK;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    state_n = PRESENT;
                    cnt_n   = '0;
                end else if (cnt == DEB_LIM) begin
                    state_n = ABSENT;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ABSENT;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decoded from debounce state; latched request is masked during
    // farm green so the controller can end green as soon as the road empties
    always_comb begin
        vehiclePresent = (state == PRESENT) || (state == FALL_CHK);
        debState       = state;
        farmSensor     = green ? vehiclePresent : (vehiclePresent | requestPending);
    end

    // Service request: an arrival outside farm green is remembered one cycle
    // (arr_q) and then latched; farm green always clears and wins over set
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            arr_q          <= 1'b0;
            requestPending <= 1'b0;
        end else begin
            arr_q <= arrival & ~green;
            if (green)
                requestPending <= 1'b0;
            else if (arr_q)
                requestPending <= 1'b1;
        end
    end

    // Saturating arrival tally, clear has priority over increment
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            vehicleTally <= '0;
        end else if (tallyClr) begin
            vehicleTally <= '0;
        end else if (arrival && (vehicleTally != '1)) begin
            vehicleTally <= vehicleTally + 1'b1;
        end
    end

endmodule

// File: doc/farm_sensor_cond.md
Name: farm_sensor_cond

Overview:
Conditions the raw farm-road vehicle detector before it reaches the traffic-light controller FSM. Provides:
- 2-flop synchroniser and symmetric debounce filter.
- A latched service request, so a vehicle that arrives and leaves during highway green still earns a farm cycle.
- A saturating vehicle tally for diagnostics.

It sits directly upstream of the controller: its farmSensor output drives the controller's farmSensor input, and it observes the controller's farmSignal output.

Parameters:
DEBOUNCE_CYCLES, 5000000, consecutive stable synchronised samples required to accept a level change (100 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
CNT_W, 23, debounce counter width.
TALLY_W, 8, vehicle tally width.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous reset, active-low (Rst==0 at a rising Clk edge resets all state)
sensorRaw  input  1  asynchronous raw loop detector, 1 = vehicle
farmSignal  input  2  controller farm lamp: 01 red, 11 green, 10 yellow
tallyClr  input  1  synchronous clear of vehicleTally
farmSensor  output  1  conditioned request to controller
vehiclePresent  output  1  debounced live presence
requestPending  output  1  latched request awaiting farm green
vehicleTally  output  TALLY_W  count of accepted arrivals, saturating
debState  output  2  debounce FSM state, for test

Behaviour:
- Reset (Rst==0): sync flops=0, debState=ABSENT, counter=0, vehiclePresent=0, requestPending=0, vehicleTally=0. The resulting farmSensor is 0. Reset mid-debounce or mid-request discards all progress.
- Synchroniser: s1<=sensorRaw, s2<=s1. Only s2 is used downstream.
- Debounce FSM, with states ABSENT=00, RISE_CHK=01, PRESENT=10, FALL_CHK=11:
  - ABSENT: when s2==1, go to RISE_CHK with cnt=1. Otherwise stay, cnt=0.
  - RISE_CHK:
    - If s2==0, go to ABSENT with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES, go to PRESENT, set vehiclePresent=1, cnt=0.
    - Else cnt+1.
  - PRESENT: when s2==0, go to FALL_CHK with cnt=1.
  - FALL_CHK:
    - If s2==1, return to PRESENT with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES, go to ABSENT, set vehiclePresent=0, cnt=0.
    - Else cnt+1.
- Latency: with sensorRaw stable, vehiclePresent changes exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new raw level. A glitch that does not hold through the full filter window produces no output change.
- vehiclePresent is 1 in PRESENT and FALL_CHK, and 0 in ABSENT and RISE_CHK.
- Arrival event: the RISE_CHK to PRESENT transition.
  - On arrival, vehicleTally increments and saturates at 2^TALLY_W-1.
  - tallyClr has priority over increment in the same cycle.
- requestPending:
  - Set on the cycle after an arrival event if farmSignal!=11 in the arrival cycle.
  - Cleared on any edge where farmSignal==11.
  - If set and clear conditions coincide, clear wins.
  - Arrival during farm green never sets it.
- farmSensor is combinational:
  - When farmSignal==11: farmSensor = vehiclePresent. This lets the controller end farm green early when the road empties.
  - Otherwise: farmSensor = vehiclePresent | requestPending.
  - No combinational loop results, because the controller derives farmSignal from its state register only.
- Illegal farmSignal 00 is treated as not green.
- Counter never exceeds DEBOUNCE_CYCLES; no wrap-around is possible.

Decomposition:
- Shared package tlc_pkg holds:
  - lamp encodings LAMP_RED=2'b01, LAMP_GREEN=2'b11, LAMP_YELLOW=2'b10;
  - debounce state encodings;
  - timing constants ONE_SEC, THREE_SEC, FIFTEEN_SEC, THIRTY_SEC, DEBOUNCE_100MS.
- One sub-module, sync_2ff (Clk, Rst, d, q), reused for other async inputs.

Test Plan:
1. DEBOUNCE_CYCLES=4, farmSignal=01, sensorRaw 0->1 held → vehiclePresent=1 and farmSensor=1 exactly 7 edges after first sampling edge; requestPending=1 one edge later; vehicleTally=1.
2. DEBOUNCE_CYCLES=4, sensorRaw high for 3 cycles then low → debState visits 01 then returns to 00; vehiclePresent, farmSensor and vehicleTally stay 0.
3. Arrival with farmSignal=01, then sensorRaw low for 10 cycles → vehiclePresent=0, but farmSensor stays 1 via requestPending. Then drive farmSignal=11 → requestPending=0 next edge, farmSensor=0 immediately.
4. farmSignal=11 with vehicle present, then sensorRaw drops → farmSensor falls to 0 exactly 7 edges later; requestPending never set.
5. TALLY_W=2, five separate debounced arrivals → vehicleTally 1,2,3,3,3. tallyClr asserted in the same cycle as an arrival → vehicleTally=0.
6. Rst=0 for one edge while debState=10 and requestPending=1 → every output 0 the next cycle; a new arrival needs the full 7-edge latency.
